// File: rtl/vga_sync_gen_if.sv
// Video timing bundle: counters, delayed sync/blank strobes, frame tick and animation phase.
// Latency: n/a (wiring only).
// Backpressure: none, free-running pixel-rate signals.
interface vga_sync_gen_if;
  logic       pausa;
  logic [9:0] h_counter;
  logic [9:0] v_counter;
  logic       hsync;
  logic       vsync;
  logic       blank_n;
  logic       frame_tick;
  logic       troca;

  modport master (
    input  pausa,
    output h_counter, v_counter, hsync, vsync, blank_n, frame_tick, troca
  );

  modport slave (
    output pausa,
    input  h_counter, v_counter, hsync, vsync, blank_n, frame_tick, troca
  );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA timing source: pixel/line counters, sync/blank strobes, frame tick and troca toggle.
// Latency: counters 0, hsync/vsync/blank_n SYNC_DELAY clocks behind the counters, frame_tick 1 register.
// Backpressure: none; pausa only freezes the animation counter, never the video timing.
module vga_sync_gen #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int SYNC_DELAY  = 2,
  parameter int ANIM_FRAMES = 30
) (
  input  logic            clk,
  input  logic            reset,
  vga_sync_gen_if.master  vid
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEG   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [7:0] ANIM_LAST = 8'(ANIM_FRAMES - 1);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       vis;
  logic       hs_n;
  logic       vs_n;
  logic       tick;
  logic [7:0] anim;
  logic       troca_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  assign vis  = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign hs_n = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
  assign vs_n = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));

  // Strobes are delayed to line up with the sprites' registered RGB path.
  generate
    if (SYNC_DELAY == 0) begin : g_direct
      assign vid.hsync   = hs_n;
      assign vid.vsync   = vs_n;
      assign vid.blank_n = vis;
    end else begin : g_pipe
      logic [SYNC_DELAY-1:0] hs_q;
      logic [SYNC_DELAY-1:0] vs_q;
      logic [SYNC_DELAY-1:0] vis_q;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          hs_q  <= '1;
          vs_q  <= '1;
          vis_q <= '0;
        end else begin
          hs_q[0]  <= hs_n;
          vs_q[0]  <= vs_n;
          vis_q[0] <= vis;
          for (int i = 1; i < SYNC_DELAY; i++) begin
            hs_q[i]  <= hs_q[i-1];
            vs_q[i]  <= vs_q[i-1];
            vis_q[i] <= vis_q[i-1];
          end
        end
      end

      assign vid.hsync   = hs_q[SYNC_DELAY-1];
      assign vid.vsync   = vs_q[SYNC_DELAY-1];
      assign vid.blank_n = vis_q[SYNC_DELAY-1];
    end
  endgenerate

  // tick is loaded on the last pixel so it is high exactly while the counters read (0,0).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick    <= 1'b0;
      anim    <= '0;
      troca_q <= 1'b0;
    end else begin
      tick <= (h_cnt == H_LAST) && (v_cnt == V_LAST);
      if (tick && !vid.pausa) begin
        if (anim == ANIM_LAST) begin
          anim    <= '0;
          troca_q <= ~troca_q;
        end else begin
          anim <= anim + 8'd1;
        end
      end
    end
  end

  assign vid.h_counter  = h_cnt;
  assign vid.v_counter  = v_cnt;
  assign vid.frame_tick = tick;
  assign vid.troca      = troca_q;

endmodule
